throw_sequencer: RTL and testbench

Turn and throw controller that sequences the projectile simulation for a two-player game. It owns `turn`, charges and latches the throw `speed`, and issues the one-cycle launch request. It waits for the simulation's `end_throw`, checks both hit-point counters for game over, then hands the turn to the other player after a settle pause. It sits between the button/UART input logic and the simulation block.

---
 rtl/variable_pkg.sv | 24 ++
 rtl/speed_charger.sv | 56 +++++
 rtl/throw_sequencer.sv | 155 +++++++++++++++
 tb/tb_throw_sequencer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/variable_pkg.sv
// Shared player ids, hit-point limit and FSM state type
// for the throw sequencer and its speed charger.
package variable_pkg;

  localparam logic PLAYER_1 = 1'b0;
  localparam logic PLAYER_2 = 1'b1;

  localparam logic [6:0] HP_MAX = 7'd100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHARGE,
    ST_LAUNCH,
    ST_FLIGHT,
    ST_SETTLE,
    ST_OVER
  } seq_state_t;

  // hp above HP_MAX means the 7-bit counter wrapped below zero
  function automatic logic hp_dead(input logic [6:0] hp);
    return (hp == 7'd0) || (hp > HP_MAX);
  endfunction

endpackage

// File: rtl/speed_charger.sv
// Throw-speed register: divider-paced saturating charge,
// direct load for remote throws, and the charging flag.
module speed_charger
  import variable_pkg::*;
#(
  parameter int CHARGE_DIV = 1_000_000,
  parameter int MIN_SPEED  = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       load_i,
  input  logic [4:0] load_val_i,
  output logic [4:0] speed_o,
  output logic       charging_o
);

  localparam int DW = (CHARGE_DIV > 1) ? $clog2(CHARGE_DIV) : 1;

  logic [DW-1:0] div_q;
  logic [4:0]    speed_q;
  logic          charging_q;
  logic          wrap;

  always_comb begin
    wrap = (div_q == DW'(CHARGE_DIV - 1));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q      <= '0;
      speed_q    <= '0;
      charging_q <= 1'b0;
    end else begin
      charging_q <= clr_i | en_i;
      if (clr_i) begin
        speed_q <= 5'(MIN_SPEED);
        div_q   <= '0;
      end else if (load_i) begin
        speed_q <= load_val_i;
      end else if (en_i) begin
        if (wrap) begin
          div_q <= '0;
          if (speed_q != 5'd31) speed_q <= speed_q + 5'd1;
        end else begin
          div_q <= div_q + DW'(1);
        end
      end
    end
  end

  assign speed_o    = speed_q;
  assign charging_o = charging_q;

endmodule

// File: rtl/throw_sequencer.sv
// Turn/throw FSM for the two-player projectile game.
// FLIGHT_TIMEOUT_EN adds a FLIGHT watchdog that forces SETTLE.
module throw_sequencer
  import variable_pkg::*;
#(
  parameter int CHARGE_DIV     = 1_000_000,
  parameter int SETTLE_CYCLES  = 30_000_000,
`ifdef FLIGHT_TIMEOUT_EN
  parameter int FLIGHT_TIMEOUT = 120_000_000,
`endif
  parameter int MIN_SPEED      = 1
) (
  input  logic       clk60MHz,
  input  logic       rst,
  input  logic       local_player,
  input  logic       btn_throw,
  input  logic       in_throw_flag,
  input  logic [4:0] in_speed,
  input  logic       end_throw,
  input  logic [6:0] hp_player1,
  input  logic [6:0] hp_player2,
  output logic       turn,
  output logic       throw_flag,
  output logic [4:0] speed,
  output logic       charging,
  output logic       game_over,
  output logic       winner
);

  localparam int SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

  seq_state_t    state_q;
  logic          turn_q;
  logic          throw_flag_q;
  logic          game_over_q;
  logic          winner_q;
  logic          armed_q;
  logic [SW-1:0] settle_cnt_q;

  logic local_turn, chg_clr, chg_en, rem_load;
  logic p1_dead, p2_dead, flight_done;

`ifdef FLIGHT_TIMEOUT_EN
  localparam int FW = $clog2(FLIGHT_TIMEOUT + 1);
  logic [FW-1:0] flight_cnt_q;
`endif

  always_comb begin
    local_turn = (turn_q == local_player);
    chg_clr    = (state_q == ST_IDLE) && local_turn
               && armed_q && btn_throw;
    chg_en     = (state_q == ST_CHARGE) && btn_throw;
    rem_load   = (state_q == ST_IDLE) && !local_turn
               && in_throw_flag;
    p1_dead    = hp_dead(hp_player1);
    p2_dead    = hp_dead(hp_player2);
`ifdef FLIGHT_TIMEOUT_EN
    flight_done = end_throw
                || (flight_cnt_q == FW'(FLIGHT_TIMEOUT - 1));
`else
    flight_done = end_throw;
`endif
  end

  speed_charger #(
    .CHARGE_DIV (CHARGE_DIV),
    .MIN_SPEED  (MIN_SPEED)
  ) u_charger (
    .clk_i      (clk60MHz),
    .rst_i      (rst),
    .clr_i      (chg_clr),
    .en_i       (chg_en),
    .load_i     (rem_load),
    .load_val_i (in_speed),
    .speed_o    (speed),
    .charging_o (charging)
  );

  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      turn_q       <= PLAYER_1;
      throw_flag_q <= 1'b0;
      game_over_q  <= 1'b0;
      winner_q     <= PLAYER_1;
      armed_q      <= 1'b0;
      settle_cnt_q <= '0;
`ifdef FLIGHT_TIMEOUT_EN
      flight_cnt_q <= '0;
`endif
    end else begin
      throw_flag_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (!btn_throw) armed_q <= 1'b1;
          if (chg_clr) begin
            state_q <= ST_CHARGE;
          end else if (rem_load) begin
            state_q <= ST_FLIGHT;
`ifdef FLIGHT_TIMEOUT_EN
            flight_cnt_q <= '0;
`endif
          end
        end
        ST_CHARGE: begin
          if (!btn_throw) state_q <= ST_LAUNCH;
        end
        ST_LAUNCH: begin
          throw_flag_q <= 1'b1;
          state_q      <= ST_FLIGHT;
`ifdef FLIGHT_TIMEOUT_EN
          flight_cnt_q <= '0;
`endif
        end
        ST_FLIGHT: begin
          if (flight_done) begin
            state_q      <= ST_SETTLE;
            settle_cnt_q <= '0;
          end
`ifdef FLIGHT_TIMEOUT_EN
          else begin
            flight_cnt_q <= flight_cnt_q + FW'(1);
          end
`endif
        end
        ST_SETTLE: begin
          // hit points are judged only on the first settle cycle
          if (settle_cnt_q == '0 && (p1_dead || p2_dead)) begin
            state_q     <= ST_OVER;
            game_over_q <= 1'b1;
            unique case (1'b1)
              p1_dead && p2_dead:  winner_q <= turn_q;
              p1_dead && !p2_dead: winner_q <= PLAYER_2;
              !p1_dead && p2_dead: winner_q <= PLAYER_1;
            endcase
          end else if (settle_cnt_q == SW'(SETTLE_CYCLES)) begin
            turn_q  <= ~turn_q;
            state_q <= ST_IDLE;
            armed_q <= 1'b0;
          end else begin
            settle_cnt_q <= settle_cnt_q + SW'(1);
          end
        end
        ST_OVER: ;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign turn       = turn_q;
  assign throw_flag = throw_flag_q;
  assign game_over  = game_over_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_throw_sequencer.sv
// Randomized self-checking bench for throw_sequencer.
// Reference model tracks turn, speed and game result.
module tb_throw_sequencer;
  import variable_pkg::*;

  localparam int CDIV = 4;
  localparam int SETL = 10;
  localparam int FTO  = 50;
  localparam int MINS = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       local_player;
  logic       btn_throw;
  logic       in_throw_flag;
  logic [4:0] in_speed;
  logic       end_throw;
  logic [6:0] hp_player1;
  logic [6:0] hp_player2;
  logic       turn;
  logic       throw_flag;
  logic [4:0] speed;
  logic       charging;
  logic       game_over;
  logic       winner;

  int n_chk = 0;
  int n_err = 0;

  logic       m_turn;
  logic [4:0] m_speed;
  logic       m_over;

  always #5 clk = ~clk;

  throw_sequencer #(
    .CHARGE_DIV     (CDIV),
    .SETTLE_CYCLES  (SETL),
`ifdef FLIGHT_TIMEOUT_EN
    .FLIGHT_TIMEOUT (FTO),
`endif
    .MIN_SPEED      (MINS)
  ) dut (
    .clk60MHz      (clk),
    .rst           (rst),
    .local_player  (local_player),
    .btn_throw     (btn_throw),
    .in_throw_flag (in_throw_flag),
    .in_speed      (in_speed),
    .end_throw     (end_throw),
    .hp_player1    (hp_player1),
    .hp_player2    (hp_player2),
    .turn          (turn),
    .throw_flag    (throw_flag),
    .speed         (speed),
    .charging      (charging),
    .game_over     (game_over),
    .winner        (winner)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic bit m_dead(input int hp);
    return (hp == 0) || (hp > 100);
  endfunction

  function automatic logic [6:0] rand_live();
    return 7'($urandom_range(1, 100));
  endfunction

  function automatic logic [6:0] rand_dead();
    if ($urandom_range(0, 1) == 0) return 7'd0;
    return 7'($urandom_range(101, 127));
  endfunction

  task automatic reset_dut();
    rst = 1'b1;
    btn_throw = 1'b0;
    in_throw_flag = 1'b0;
    in_speed = '0;
    end_throw = 1'b0;
    hp_player1 = 7'd100;
    hp_player2 = 7'd100;
    local_player = 1'($urandom_range(0, 1));
    tick(2);
    check("rst_turn", turn, PLAYER_1);
    check("rst_speed", speed, 0);
    check("rst_flag", throw_flag, 0);
    check("rst_charging", charging, 0);
    check("rst_over", game_over, 0);
    check("rst_winner", winner, PLAYER_1);
    rst = 1'b0;
    m_turn = PLAYER_1;
    m_speed = '0;
    m_over = 1'b0;
  endtask

  // ends one cycle after the launch pulse, in FLIGHT
  task automatic local_throw(input int hold);
    int s;
    btn_throw = 1'b0;
    tick(1);
    btn_throw = 1'b1;
    tick(1);
    check("chg_on", charging, 1);
    tick(hold);
    s = MINS + hold / CDIV;
    m_speed = (s > 31) ? 5'd31 : 5'(s);
    check("chg_speed", speed, m_speed);
    btn_throw = 1'b0;
    tick(1);
    check("flag_early", throw_flag, 0);
    check("chg_off", charging, 0);
    tick(1);
    check("flag_pulse", throw_flag, 1);
    tick(1);
    check("flag_one_cyc", throw_flag, 0);
    check("speed_held", speed, m_speed);
  endtask

  task automatic remote_throw(input logic [4:0] v);
    btn_throw = 1'b1;
    tick(3);
    check("rem_btn_ign", charging, 0);
    btn_throw = 1'b0;
    in_speed = v;
    in_throw_flag = 1'b1;
    tick(1);
    in_throw_flag = 1'b0;
    m_speed = v;
    check("rem_speed", speed, m_speed);
    check("rem_noflag", throw_flag, 0);
    in_speed = ~v;
    in_throw_flag = 1'b1;
    tick(1);
    in_throw_flag = 1'b0;
    check("flight_itf_ign", speed, m_speed);
    check("flight_noflag", throw_flag, 0);
  endtask

  task automatic do_throw(input int hold);
    if (m_turn == local_player) begin
      in_speed = 5'($urandom);
      in_throw_flag = 1'b1;
      tick(1);
      in_throw_flag = 1'b0;
      check("loc_itf_ign", speed, m_speed);
      local_throw(hold);
    end else begin
      remote_throw(5'($urandom_range(0, 31)));
    end
  endtask

  task automatic finish_flight(input logic [6:0] h1,
                               input logic [6:0] h2,
                               input bit hold_btn);
    bit d1, d2;
    logic w;
    hp_player1 = h1;
    hp_player2 = h2;
    btn_throw = hold_btn;
    end_throw = 1'b1;
    tick(1);
    end_throw = 1'b0;
    d1 = m_dead(int'(h1));
    d2 = m_dead(int'(h2));
    if (d1 || d2) begin
      w = (d1 && d2) ? m_turn : (d1 ? PLAYER_2 : PLAYER_1);
      m_over = 1'b1;
      tick(1);
      check("over_flag", game_over, 1);
      check("over_winner", winner, w);
      for (int i = 0; i < 2; i++) begin
        btn_throw = 1'b0;
        tick(1);
        btn_throw = 1'b1;
        in_throw_flag = 1'b1;
        in_speed = ~m_speed;
        tick(3);
        in_throw_flag = 1'b0;
        check("over_charge", charging, 0);
        check("over_flag_out", throw_flag, 0);
        check("over_speed", speed, m_speed);
        check("over_sticky", game_over, 1);
        check("over_turn", turn, m_turn);
      end
      btn_throw = 1'b0;
    end else begin
      tick(SETL);
      check("settle_hold", turn, m_turn);
      tick(1);
      m_turn = ~m_turn;
      check("turn_toggle", turn, m_turn);
      check("settle_live", game_over, 0);
      if (hold_btn) begin
        tick(3);
        check("held_btn_ign", charging, 0);
        btn_throw = 1'b0;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_dut();
    end_throw = 1'b1;
    tick(1);
    end_throw = 1'b0;
    tick(SETL + 3);
    check("idle_endt_ign", turn, m_turn);

    for (int g = 0; g < 3; g++) begin
      reset_dut();
      for (int r = 0; r < 6; r++) begin
        do_throw((r == 0) ? 5 * CDIV : $urandom_range(0, 40));
        finish_flight(rand_live(), rand_live(),
                      1'($urandom_range(0, 1)));
      end
      do_throw($urandom_range(0, 20));
      unique case (g)
        0: finish_flight(rand_live(), rand_dead(), 1'b0);
        1: finish_flight(rand_dead(), rand_live(), 1'b0);
        default: finish_flight(rand_dead(), rand_dead(), 1'b0);
      endcase
    end

    reset_dut();
    do_throw(2);
    finish_flight(7'd100, 7'd118, 1'b0);
    check("wrap_winner", winner, PLAYER_1);

    reset_dut();
    if (m_turn != local_player) begin
      do_throw(0);
      finish_flight(7'd100, 7'd100, 1'b0);
    end
    local_throw(200 * CDIV);
    check("sat_speed", speed, 31);
    finish_flight(7'd100, 7'd100, 1'b0);

    if (m_turn != local_player) begin
      do_throw(0);
      finish_flight(7'd100, 7'd100, 1'b0);
    end
    local_throw(3);
`ifdef FLIGHT_TIMEOUT_EN
    tick(FTO - 1 + SETL);
    check("tmo_hold", turn, m_turn);
    tick(1);
    m_turn = ~m_turn;
    check("tmo_toggle", turn, m_turn);
`else
    tick(FTO + SETL + 20);
    check("no_tmo", turn, m_turn);
    finish_flight(7'd100, 7'd100, 1'b0);
`endif

    do_throw(5);
    reset_dut();

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
